instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, address width in bits.
REQ-002 SHALL have parameter WORD_SIZE, default 32, instruction/data word width in bits.
REQ-003 SHALL have parameter BYTES, default 4, byte lanes per word.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch byte address.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port redirect_valid, input, 1, PC redirect request (branch/jump/trap).
REQ-008 SHALL have port redirect_pc, input, ADDR_SIZE, redirect target byte address.
REQ-009 SHALL have port inst_valid, output, 1, instruction available to decode.
REQ-010 SHALL have port inst_ready, input, 1, decode accepts instruction.
REQ-011 SHALL have port inst_pc, output, ADDR_SIZE, byte address of presented instruction.
REQ-012 SHALL have port inst_data, output, WORD_SIZE, presented instruction word.
REQ-013 SHALL have ports im_oe (out, 1), im_web (out, BYTES), im_addr (out, ADDR_SIZE), im_DI (out, WORD_SIZE), im_DO (in, WORD_SIZE) driving the instruction SRAM wrapper.

Function
REQ-014 SHALL drive im_web = all ones (no writes, active-low) and im_DI = 0 at all times.
REQ-015 SHALL drive im_addr = {2'b00, fetch_addr[ADDR_SIZE-1:2]} (word address); byte offset bits of any PC are forced to 0.
REQ-016 SHALL treat the SRAM as 1-cycle read latency: im_oe high at cycle T -> im_DO valid at T+1.
REQ-017 SHALL buffer responses with their PC in a 2-entry FIFO; inst_valid/inst_pc/inst_data reflect the FIFO head.
REQ-018 SHALL issue a read (im_oe=1) in a cycle iff count + inflight - (inst_valid & inst_ready) < 2, where count = FIFO occupancy, inflight = 1 if a live read was issued last cycle.
REQ-019 SHALL advance pc by 4 on every issue, wrapping modulo 2^ADDR_SIZE.
REQ-020 SHALL transfer an instruction only on inst_valid & inst_ready; inst_pc/inst_data SHALL hold stable while inst_valid & !inst_ready.
REQ-021 SHALL sustain one instruction per cycle with inst_ready held high, no bubbles after the pipeline fills.
REQ-022 On redirect_valid: flush FIFO, discard the in-flight response next cycle, force inst_valid = 0 that cycle (no handshake counted), issue at redirect_pc same cycle, pc <= redirect_pc + 4.
REQ-023 Redirect while FIFO full or decode stalled SHALL still flush and issue in the same cycle.
REQ-024 Without bypass, first instruction after reset release or redirect SHALL appear at inst_valid 2 cycles after its issue.

Reset
REQ-025 While rst = 0: pc = RESET_PC, FIFO empty, inflight = 0, inst_valid = 0, im_oe = 0, inst_pc = 0, inst_data = 0.
REQ-026 Reset asserted mid-operation SHALL abort all in-flight and buffered fetches; the first cycle after release SHALL issue RESET_PC.

Configuration
REQ-027 Macro IFU_BYPASS_EN defined: when FIFO empty and a live response arrives, it SHALL be presented on inst_valid combinationally from im_DO that cycle (latency 1), and written to the FIFO only if not accepted.
REQ-028 Macro IFU_BYPASS_EN undefined: all responses SHALL pass through the FIFO (latency 2); no combinational path im_DO -> inst_*.

Structure
REQ-029 Package ifu_pkg SHALL hold ADDR_SIZE/WORD_SIZE/BYTES defaults, RESET_PC default, and the FIFO entry typedef {pc, data}.
REQ-030 The 2-entry FIFO SHALL be sub-module ifu_fifo (push, pop, flush, count, head); pc/issue/credit logic stays in instr_fetch_unit.

Verification
REQ-031 Reset release, RESET_PC=0, inst_ready=1 -> im_addr 0,1,2,... on consecutive cycles; inst_pc 0x0,0x4,0x8 starting cycle 2 (cycle 1 with IFU_BYPASS_EN), one per cycle.
REQ-032 inst_ready=0 for 5 cycles -> at most 2 entries buffered, im_oe low once full, inst_pc/inst_data stable; on release no instruction lost or duplicated.
REQ-033 redirect_valid with redirect_pc=0x100 while FIFO full -> inst_valid=0 that cycle, im_addr=0x40 same cycle, next delivered inst_pc=0x100, no stale PCs observed.
REQ-034 redirect_pc=0x203 -> fetch at byte 0x200, inst_pc=0x200 then 0x204.
REQ-035 pc=0xFFFF_FFFC, ready=1 -> next inst_pc=0x0000_0000.
REQ-036 rst pulled low with 2 buffered and 1 in flight -> inst_valid=0 immediately; after release first inst_pc=RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared defaults and the buffered-instruction entry type for the fetch unit.
package ifu_pkg;

  localparam int                IFU_ADDR_SIZE = 32;
  localparam int                IFU_WORD_SIZE = 32;
  localparam int                IFU_BYTES     = 4;
  localparam logic [31:0]       IFU_RESET_PC  = 32'h0000_0000;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [IFU_ADDR_SIZE-1:0] pc;
    logic [IFU_WORD_SIZE-1:0] data;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry response buffer between the instruction SRAM and decode.
// The entry type is a parameter so the top can match its own widths.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter type entry_t = ifu_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   push_ok;
  logic   pop_ok;

  // Pops never underflow; a push into a full buffer only lands alongside a pop.
  always_comb begin
    pop_ok  = pop & (count != 2'd0);
    push_ok = push & ((count != 2'd2) | pop_ok);
  end

  // Storage, pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC, 1-cycle-latency SRAM reads, a
// 2-entry response buffer and redirect handling.
// Optional macro IFU_BYPASS_EN: present a response arriving into an empty
// buffer straight from im_DO in the same cycle (fetch latency 1 instead of 2).
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                    ADDR_SIZE = IFU_ADDR_SIZE,
  parameter int                    WORD_SIZE = IFU_WORD_SIZE,
  parameter int                    BYTES     = IFU_BYTES,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC  = ADDR_SIZE'(IFU_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ADDR_SIZE-1:0] inst_pc,
  output logic [WORD_SIZE-1:0] inst_data,
  output logic                 im_oe,
  output logic [BYTES-1:0]     im_web,
  output logic [ADDR_SIZE-1:0] im_addr,
  output logic [WORD_SIZE-1:0] im_DI,
  input  logic [WORD_SIZE-1:0] im_DO
);

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] data;
  } entry_t;

  logic [ADDR_SIZE-1:0] pc;
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic [ADDR_SIZE-1:0] issue_pc;
  logic [ADDR_SIZE-1:0] inflight_pc;
  logic                 inflight;
  logic                 live_resp;
  logic                 issue;
  logic                 fire;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [1:0]           count;
  entry_t               head;
  entry_t               resp;
  entry_t               present;

  // Address selection, handshake, credit check and presentation mux.
  always_comb begin
    fetch_addr = redirect_valid ? redirect_pc : pc;
    issue_pc   = {fetch_addr[ADDR_SIZE-1:2], 2'b00};
    // A response arriving in a redirect cycle belongs to the old stream.
    live_resp  = inflight & ~redirect_valid;
    fifo_empty = (count == 2'd0);
    resp       = '{pc: inflight_pc, data: im_DO};
`ifdef IFU_BYPASS_EN
    inst_valid = ~redirect_valid & (~fifo_empty | live_resp);
    present    = fifo_empty ? resp : head;
    push       = live_resp & ~(fifo_empty & inst_ready);
`else
    inst_valid = ~redirect_valid & ~fifo_empty;
    present    = head;
    push       = live_resp;
`endif
    fire       = inst_valid & inst_ready;
    pop        = fire & ~fifo_empty;
    // Buffered plus outstanding, less what decode takes now, must stay below 2.
    issue      = rst & (redirect_valid |
                        (({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(fire))));
    inst_pc    = inst_valid ? present.pc   : '0;
    inst_data  = inst_valid ? present.data : '0;
  end

  assign im_oe   = issue;
  assign im_web  = '1;
  assign im_DI   = '0;
  assign im_addr = {2'b00, fetch_addr[ADDR_SIZE-1:2]};

  // PC advance and tracking of the single read that can be outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= issue_pc + ADDR_SIZE'(4);
        inflight_pc <= issue_pc;
      end
    end
  end

  ifu_fifo #(.entry_t(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (resp),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver pushes the expected PC
// stream on reset/redirect, a negedge monitor pops and compares on each
// accepted instruction and checks the issue/credit and timing rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        im_oe;
  logic [3:0]  im_web;
  logic [31:0] im_addr;
  logic [31:0] im_DI;
  logic [31:0] im_DO;

  instr_fetch_unit #(
    .ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data),
    .im_oe(im_oe), .im_web(im_web), .im_addr(im_addr),
    .im_DI(im_DI), .im_DO(im_DO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM model: one-cycle read latency.
  always @(posedge clk) if (im_oe) im_DO <= mem_word(im_addr);

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state.
  int          since = -1;
  int          occ = 0;
  bit          hold_v = 0;
  logic [31:0] hold_pc, hold_data;

  always @(negedge clk) begin
    logic [31:0] e;
    int          f;
    if (!rst) begin
      check("reset_valid", inst_valid, 0);
      check("reset_oe", im_oe, 0);
      check("reset_pc", inst_pc, 0);
      check("reset_data", inst_data, 0);
      since = -1; occ = 0; hold_v = 0;
    end else begin
      check("im_web", im_web, 4'hF);
      check("im_DI", im_DI, 0);
      if (redirect_valid) begin
        check("redir_valid", inst_valid, 0);
        check("redir_oe", im_oe, 1);
        check("redir_addr", im_addr, {2'b00, redirect_pc[31:2]});
        since = 0; occ = 1; hold_v = 0;
      end else begin
        since++;
        check("valid_timing", inst_valid, (since >= LAT));
        if (hold_v) begin
          check("stall_pc", inst_pc, hold_pc);
          check("stall_data", inst_data, hold_data);
        end
        f = (inst_valid && inst_ready) ? 1 : 0;
        check("issue_rule", im_oe, ((occ - f) < 2));
        if (f == 1) begin
          if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_empty: got pc %h expected none", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e);
            check("inst_data", inst_data, mem_word({2'b00, e[31:2]}));
            if (exp_q.size() == 0) begin
              last_exp = last_exp + 32'd4;
              exp_q.push_back(last_exp);
            end
          end
        end
        occ = occ - f + (im_oe ? 1 : 0);
        check("occupancy", (occ <= 2), 1);
        hold_v    = inst_valid & ~inst_ready;
        hold_pc   = inst_pc;
        hold_data = inst_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_stream(input logic [31:0] t);
    exp_q.delete();
    last_exp = {t[31:2], 2'b00};
    exp_q.push_back(last_exp);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    restart_stream(t);
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    restart_stream(RESET_PC);
    repeat (cycles) step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #1 rst = 1'b0;
    restart_stream(RESET_PC);
    repeat (3) step();
    rst = 1'b1;
    // Word addresses 0,1,2,... on consecutive cycles after release.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("boot_addr", im_addr, k);
      step();
    end
    repeat (10) step();
    // Decode stall, then release.
    inst_ready = 1'b0; repeat (5) step();
    inst_ready = 1'b1; repeat (6) step();
    // Redirect while buffer full and decode stalled.
    inst_ready = 1'b0; repeat (4) step();
    do_redirect(32'h0000_0100);
    inst_ready = 1'b1; repeat (6) step();
    // Unaligned target and address wrap.
    do_redirect(32'h0000_0203); repeat (6) step();
    do_redirect(32'hFFFF_FFF8); repeat (6) step();
    // Reset with buffered fetches.
    inst_ready = 1'b0; repeat (3) step();
    do_reset(2);
    inst_ready = 1'b1; repeat (8) step();
    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 249) == 0) do_reset(1 + $urandom_range(0, 2));
      else if ($urandom_range(0, 19) == 0) do_redirect($urandom());
      else step();
    end
    inst_ready = 1'b1;
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
